// File: rtl/divider_32b.sv
// rtl/divider_32b.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module divider_32b #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic            sel_rem;       // 1: REM/REMU, 0: DIV/DIVU
    logic [XLEN-1:0] dividend_q;    // raw dividend, needed for divide-by-zero remainder
    logic [XLEN-1:0] divisor_mag;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   count;
    logic            fast;          // divide-by-zero or signed overflow: skip the iteration
    logic            div_zero_q;
    logic            neg_quo;
    logic            neg_rem;

    logic            is_signed;
    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;
    logic            div_zero;
    logic            overflow;
    logic            accept;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] shifted_rem;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fast_result;

    // Operand decode, one restoring step, and final sign fix-up
    always_comb begin
        is_signed    = ~op[0];
        dividend_abs = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
        divisor_abs  = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
        div_zero     = (divisor == '0);
        overflow     = is_signed && (dividend == MIN_NEG) && (divisor == '1);
        accept       = start && ((state == S_IDLE) || (state == S_DONE));
        // The bit shifted out of rem acts as the carry so the trial never loses it.
        trial        = {rem, quo[XLEN-1]} - {1'b0, divisor_mag};
        shifted_rem  = {rem[XLEN-2:0], quo[XLEN-1]};
        quo_fix      = neg_quo ? (~quo + 1'b1) : quo;
        rem_fix      = neg_rem ? (~rem + 1'b1) : rem;
        if (div_zero_q) begin
            fast_result = sel_rem ? dividend_q : '1;
        end else begin
            fast_result = sel_rem ? '0 : MIN_NEG;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            result      <= '0;
            sel_rem     <= 1'b0;
            dividend_q  <= '0;
            divisor_mag <= '0;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            fast        <= 1'b0;
            div_zero_q  <= 1'b0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        sel_rem     <= op[1];
                        dividend_q  <= dividend;
                        divisor_mag <= divisor_abs;
                        quo         <= dividend_abs;
                        rem         <= '0;
                        count       <= '0;
                        fast        <= div_zero | overflow;
                        div_zero_q  <= div_zero;
                        neg_quo     <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        neg_rem     <= is_signed && dividend[XLEN-1];
                        state       <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (fast) begin
                        result <= fast_result;
                        state  <= S_DONE;
                    end else begin
                        if (!trial[XLEN]) begin
                            rem <= trial[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= shifted_rem;
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                        if (count == LAST_STEP) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    result <= sel_rem ? rem_fix : quo_fix;
                    state  <= S_DONE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_divider_32b.sv
// tb/tb_divider_32b.sv - self-checking bench for divider_32b against an arithmetic model
module tb_divider_32b;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    divider_32b #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RISC-V division semantics computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) begin
            uq = a / b;
            ur = a % b;
            return o[1] ? ur : uq;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model state: cycles counted in rising edges; lat is edges from accept to the done cycle
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_acc = 0;
    int          m_lat = 0;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_held = 32'd0;
    bit          mon_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            m_held   = 32'd0;
        end else begin
            if (m_active && (cyc - 1 == m_acc + m_lat)) begin
                m_active = 1'b0;
                m_held   = m_res;
            end
            if (!m_active && start) begin
                m_active = 1'b1;
                m_acc    = cyc;
                m_lat    = is_fast(op, dividend, divisor) ? 1 : 33;
                m_res    = ref_res(op, dividend, divisor);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic        exp_busy, exp_done;
            logic [31:0] exp_r;
            exp_busy = m_active;
            exp_done = m_active && (cyc == m_acc + m_lat);
            exp_r    = exp_done ? m_res : m_held;
            chk(busy === exp_busy, "busy", {31'd0, busy}, {31'd0, exp_busy});
            chk(done === exp_done, "done", {31'd0, done}, {31'd0, exp_done});
            chk(result === exp_r, "result", result, exp_r);
        end
    end

    task automatic directed(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] lit, input int lat_lit, input string name);
        int n;
        bit got;
        @(posedge clk);
        #2;
        start = 1'b1;
        op = o;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #2;
        start = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
            else n++;
        end
        chk(got && n == lat_lit, {name, "_latency"}, 32'(n), 32'(lat_lit));
        chk(result === lit, name, result, lit);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, dones;

        @(posedge clk);
        #2;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk(result === 32'd0 && busy === 1'b0 && done === 1'b0, "reset_state", result, 32'd0);

        chk(ref_res(2'b01, 32'd100, 32'd7) == 32'd14, "model_divu", ref_res(2'b01, 32'd100, 32'd7), 32'd14);
        chk(ref_res(2'b00, 32'h8000_0000, 32'hFFFF_FFFF) == 32'h8000_0000, "model_ovf",
            ref_res(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        directed(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        directed(2'b11, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
        directed(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
        directed(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
        directed(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
        directed(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
        directed(2'b01, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        directed(2'b11, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, "remu_by0");
        directed(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
        directed(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        directed(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        directed(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_no_ovf");
        directed(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
        directed(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, "remu_max_16");
        directed(2'b01, 32'd3, 32'd5, 32'd0, 33, "divu_3_5");
        directed(2'b11, 32'd3, 32'd5, 32'd3, 33, "remu_3_5");

        // Ignored start while busy, then reset mid-operation
        @(posedge clk);
        #2;
        start = 1'b1;
        op = 2'b01;
        dividend = 32'd1000;
        divisor = 32'd3;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        start = 1'b1;
        op = 2'b11;
        dividend = 32'd55;
        divisor = 32'd9;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk(busy === 1'b0 && done === 1'b0 && result === 32'd0, "abort_reset", result, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk(dones == 0, "abort_no_done", 32'(dones), 32'd0);
        directed(2'b01, 32'd1000, 32'd3, 32'd333, 33, "after_abort");

        // Randomized traffic: starts at any time, including during busy and done
        repeat (4000) begin
            @(posedge clk);
            #2;
            start    = ($urandom_range(0, 7) == 0);
            op       = 2'($urandom_range(0, 3));
            dividend = pick();
            divisor  = pick();
            rst      = ($urandom_range(0, 999) == 0);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        rst = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(busy === 1'b0, "drain_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
